alu_core: RTL and testbench



---
 rtl/alu_core.sv | 111 +++++++++++
 tb/tb_alu_core.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// ============================================================================
// alu_core: registered WIDTH-bit ALU (add/sub with carry, logic ops, shift-left).
// Optional macro ALU_FLAGS_EN adds registered zero/neg/ovf flags. Rev 1.0
// ============================================================================
`default_nettype none

module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] w,
  input  logic             cin,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] d,
  output logic             cout
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam logic [2:0] C_OP_ADD = 3'b000;
  localparam logic [2:0] C_OP_ADC = 3'b001;
  localparam logic [2:0] C_OP_SUB = 3'b010;
  localparam logic [2:0] C_OP_SBB = 3'b011;
  localparam logic [2:0] C_OP_AND = 3'b100;
  localparam logic [2:0] C_OP_OR  = 3'b101;
  localparam logic [2:0] C_OP_XOR = 3'b110;
  localparam logic [2:0] C_OP_SHL = 3'b111;

  logic [WIDTH-1:0] w_b;
  logic             w_ci;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_r;
  logic             w_c;
  logic             w_ovf;

  // One shared adder: subtract forms feed ~w, carry-in chosen per opcode.
  always_comb begin
    w_b  = w;
    w_ci = 1'b0;
    case (s)
      C_OP_ADD: begin w_b = w;  w_ci = 1'b0; end
      C_OP_ADC: begin w_b = w;  w_ci = cin;  end
      C_OP_SUB: begin w_b = ~w; w_ci = 1'b1; end
      C_OP_SBB: begin w_b = ~w; w_ci = cin;  end
      default:  begin w_b = w;  w_ci = 1'b0; end
    endcase
    w_sum = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_ci};
  end

  // Unknown select falls to default so X/Z never leaks into the result.
  always_comb begin
    w_r   = '0;
    w_c   = 1'b0;
    w_ovf = 1'b0;
    case (s)
      C_OP_ADD, C_OP_ADC, C_OP_SUB, C_OP_SBB: begin
        w_r   = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_ovf = (a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      C_OP_AND: w_r = a & w;
      C_OP_OR:  w_r = a | w;
      C_OP_XOR: w_r = a ^ w;
      C_OP_SHL: begin
        w_r = {a[WIDTH-2:0], cin};
        w_c = a[WIDTH-1];
      end
      default: begin
        w_r   = '0;
        w_c   = 1'b0;
        w_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d    <= '0;
      cout <= 1'b0;
    end else begin
      d    <= w_r;
      cout <= w_c;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      zero <= (w_r == '0);
      neg  <= w_r[WIDTH-1];
      ovf  <= w_ovf;
    end
  end
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
// ============================================================================
// tb_alu_core: directed self-checking bench for alu_core. Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_core;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] w;
  logic             cin;
  logic [2:0]       s;
  logic [WIDTH-1:0] d;
  logic             cout;
`ifdef ALU_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;
`endif

  int checks;
  int failures;

  alu_core #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .w    (w),
    .cin  (cin),
    .s    (s),
    .d    (d),
    .cout (cout)
`ifdef ALU_FLAGS_EN
    ,
    .zero (zero),
    .neg  (neg),
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input string tag, input logic [31:0] ta, input logic [31:0] tw,
                       input logic tcin, input logic [2:0] ts,
                       input logic [31:0] exp_d, input logic exp_c);
    @(negedge clk);
    a = ta; w = tw; cin = tcin; s = ts;
    @(posedge clk);
    #1;
    check({tag, "_d"}, 64'(d), 64'(exp_d));
    check({tag, "_c"}, 64'(cout), 64'(exp_c));
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] exp_d;
    logic        exp_c;
  } vec_t;

  vec_t ops [8];

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    a = '0; w = '0; cin = 1'b0; s = 3'b000;

    ops[0] = '{3'b000, 32'h000000E0, 1'b1};
    ops[1] = '{3'b001, 32'h000000E1, 1'b1};
    ops[2] = '{3'b010, 32'hFFFFFF00, 1'b1};
    ops[3] = '{3'b011, 32'hFFFFFF00, 1'b1};
    ops[4] = '{3'b100, 32'h000000F0, 1'b0};
    ops[5] = '{3'b101, 32'hFFFFFFF0, 1'b0};
    ops[6] = '{3'b110, 32'hFFFFFF00, 1'b0};
    ops[7] = '{3'b111, 32'hFFFFFFE1, 1'b1};

    #2;
    check("reset_d", 64'(d), 64'h0);
    check("reset_c", 64'(cout), 64'h0);
`ifdef ALU_FLAGS_EN
    check("reset_zero", 64'(zero), 64'h0);
    check("reset_neg", 64'(neg), 64'h0);
    check("reset_ovf", 64'(ovf), 64'h0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      apply($sformatf("op%0d", i), 32'hFFFFFFF0, 32'h000000F0, 1'b1,
            ops[i].sel, ops[i].exp_d, ops[i].exp_c);

    apply("sub_borrow", 32'h0000000F, 32'h00000010, 1'b0, 3'b010, 32'hFFFFFFFF, 1'b0);
    apply("sbb_borrow", 32'h0000000F, 32'h00000010, 1'b0, 3'b011, 32'hFFFFFFFE, 1'b0);
    apply("shl_cin0",   32'h40000001, 32'h0,        1'b0, 3'b111, 32'h80000002, 1'b0);
    apply("add_nocin",  32'h00000005, 32'h00000003, 1'b1, 3'b000, 32'h00000008, 1'b0);

    apply("adc_chain",  32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b001, 32'h00000000, 1'b1);
`ifdef ALU_FLAGS_EN
    check("chain_zero", 64'(zero), 64'h1);
    check("chain_ovf", 64'(ovf), 64'h0);
`endif
    apply("add_sovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 3'b000, 32'h80000000, 1'b0);
`ifdef ALU_FLAGS_EN
    check("sovf_neg", 64'(neg), 64'h1);
    check("sovf_ovf", 64'(ovf), 64'h1);
    check("sovf_zero", 64'(zero), 64'h0);
`endif

    // Async reset mid-cycle while d is nonzero.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_d", 64'(d), 64'h0);
    check("arst_c", 64'(cout), 64'h0);
`ifdef ALU_FLAGS_EN
    check("arst_neg", 64'(neg), 64'h0);
`endif
    a = 32'h00000001; w = 32'h00000002; cin = 1'b0; s = 3'b000;
    @(posedge clk);
    #1;
    check("arst_hold_d", 64'(d), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_rel_d", 64'(d), 64'h0);
    @(posedge clk);
    #1;
    check("arst_first_d", 64'(d), 64'h3);
    check("arst_first_c", 64'(cout), 64'h0);

    // Latency: select changes between edges must not reach d until the edge.
    apply("lat_base", 32'h00000005, 32'h00000003, 1'b0, 3'b000, 32'h00000008, 1'b0);
    @(negedge clk);
    s = 3'b110;
    #1;
    check("lat_hold1", 64'(d), 64'h8);
    s = 3'b100;
    #1;
    check("lat_hold2", 64'(d), 64'h8);
    @(posedge clk);
    #1;
    check("lat_edge_d", 64'(d), 64'h1);
    check("lat_edge_c", 64'(cout), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
